// File: rtl/fetch_unit_pkg.sv
// Shared rv32i pipeline definitions used by the fetch stage.
`timescale 1ns/1ps
package fetch_unit_pkg;

  localparam int unsigned XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Sequential successor of a word address (wraps at 2^32).
  function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/fetch_unit_fifo.sv
// fetch_fifo: synchronous FIFO with flush; push on a full FIFO is accepted
// only when a pop happens in the same cycle.
`timescale 1ns/1ps
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter  int unsigned WIDTH = XLEN,
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign w_pop  = pop && (r_count != '0);
  assign w_push = push && ((r_count != CW'(DEPTH)) || w_pop);

  // Pointer and occupancy tracking; flush empties the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Storage array; contents beyond count are don't-care.
  always_ff @(posedge clk) begin
    if (w_push && !flush) r_mem[r_wr_ptr] <= push_data;
  end

  assign head_data = r_mem[r_rd_ptr];
  assign empty     = (r_count == '0);
  assign full      = (r_count == CW'(DEPTH));
  assign count     = r_count;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: rv32i instruction-fetch stage with credit-based issue,
// in-order response tagging and redirect flush.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (misaligned redirect trap).
`timescale 1ns/1ps
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned FQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_f,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic        if_misalign
);

  import fetch_unit_pkg::*;

  localparam int unsigned CW = $clog2(FQ_DEPTH) + 1;
  localparam int unsigned EW = $bits(fetch_entry_t);

  logic [XLEN-1:0] r_fetch_pc;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_drop_cnt;

  logic            w_issue_block;
  logic            w_credit;
  logic            w_req_fire;
  logic            w_rsp_fire;
  logic            w_rsp_keep;
  logic            w_if_pop;
  logic [XLEN-1:0] w_redirect_target;
  logic [XLEN-1:0] w_tag_head;
  logic            w_tag_empty;
  logic            w_tag_full;
  logic [CW-1:0]   w_tag_count;
  logic            w_iq_empty;
  logic            w_iq_full;
  logic [CW-1:0]   w_iq_count;
  fetch_entry_t    w_rsp_entry;
  fetch_entry_t    w_head;

  // Low target bits never reach the fetch PC; the check build traps on them.
  assign w_redirect_target = redirect_pc & ~XLEN'(3);

`ifdef FETCH_MISALIGN_CHECK_EN
  logic r_misalign;

  // Sticky misalign flag, re-evaluated on every redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_misalign <= 1'b0;
    else if (redirect) r_misalign <= |redirect_pc[1:0];
  end

  assign w_issue_block = r_misalign;
`else
  assign w_issue_block = 1'b0;
`endif

  assign if_misalign = w_issue_block;

  // Every accepted request must own a queue slot when its response lands.
  assign w_credit   = ({1'b0, r_outstanding} + {1'b0, w_iq_count}) < (CW + 1)'(FQ_DEPTH);
  assign imem_req_valid = rst_n && w_credit && !redirect && !w_issue_block;
  assign imem_req_addr  = r_fetch_pc;
  assign w_req_fire = imem_req_valid && imem_req_ready;

  // Stray responses with nothing outstanding are ignored.
  assign w_rsp_fire = imem_rsp_valid && (r_outstanding != '0);
  assign w_rsp_keep = w_rsp_fire && (r_drop_cnt == '0) && !redirect;
  assign w_if_pop   = !w_iq_empty && !stall_f && !redirect;

  assign w_rsp_entry.pc    = w_tag_head;
  assign w_rsp_entry.instr = imem_rsp_data;

  // Fetch PC: redirect wins, otherwise advance on each accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_fetch_pc <= RESET_PC;
    else if (redirect)   r_fetch_pc <= w_redirect_target;
    else if (w_req_fire) r_fetch_pc <= pc_next(r_fetch_pc);
  end

  // In-flight accounting; a redirect marks every surviving request as stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else if (redirect) begin
      r_outstanding <= r_outstanding - CW'(w_rsp_fire);
      r_drop_cnt    <= r_outstanding - CW'(w_rsp_fire);
    end else begin
      r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(w_rsp_fire);
      if (w_rsp_fire && (r_drop_cnt != '0)) r_drop_cnt <= r_drop_cnt - CW'(1);
    end
  end

  fetch_fifo #(
    .WIDTH (XLEN),
    .DEPTH (FQ_DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect),
    .push      (w_req_fire),
    .push_data (r_fetch_pc),
    .pop       (w_rsp_keep),
    .head_data (w_tag_head),
    .empty     (w_tag_empty),
    .full      (w_tag_full),
    .count     (w_tag_count)
  );

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (FQ_DEPTH)
  ) u_instr_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect),
    .push      (w_rsp_keep),
    .push_data (w_rsp_entry),
    .pop       (w_if_pop),
    .head_data (w_head),
    .empty     (w_iq_empty),
    .full      (w_iq_full),
    .count     (w_iq_count)
  );

  assign if_valid    = !w_iq_empty;
  assign if_instr    = w_iq_empty ? NOP_INSTR : w_head.instr;
  assign if_pc       = w_iq_empty ? '0 : w_head.pc;
  assign if_pc_plus4 = pc_next(if_pc);

  a_no_stray_rsp: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> (r_outstanding != '0));
  a_tag_room: assert property (@(posedge clk) disable iff (!rst_n)
    w_req_fire |-> !w_tag_full);
  a_tag_avail: assert property (@(posedge clk) disable iff (!rst_n)
    w_rsp_keep |-> !w_tag_empty);
  a_iq_room: assert property (@(posedge clk) disable iff (!rst_n)
    w_rsp_keep |-> (!w_iq_full || w_if_pop));
  a_tag_balance: assert property (@(posedge clk) disable iff (!rst_n)
    (w_tag_count + r_drop_cnt) == r_outstanding);

endmodule
